multicycle_main_control: RTL and testbench

//  Multi-cycle main control FSM for the 64-bit RISC-V datapath; directly upstream of ALU_CU.

---
 rtl/multicycle_main_control.sv | 145 ++++++++++++++
 tb/tb_multicycle_main_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the 64-bit RISC-V datapath (ld, sd, beq, R-type).
// Sequences fetch/decode/execute over 3-5 cycles and counts retired instructions.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcEn,
  output logic             pcSource,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegalOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instrCount
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // memReady is a completion strobe: a memory state holds its strobes until
  // the cycle memReady is high, and that cycle is the one that advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    retire    = 1'b0;
    pcEn      = 1'b0;
    pcSource  = 1'b0;
    IorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    ALUOp     = 2'b00;
    illegalOp = 1'b0;
    // Outputs are forced low for the whole reset pulse, not just after the edge.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcEn    = memReady;
          state_d = memReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          aluSrcB = 2'b10;
          case (opcode)
            OP_LD, OP_SD: state_d = S_MEMADR;
            OP_R:         state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            default: begin
              state_d   = S_FETCH;
              illegalOp = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          state_d = (op_q == OP_SD) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          memRead = 1'b1;
          IorD    = 1'b1;
          state_d = memReady ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
          retire   = 1'b1;
        end
        S_MEMWRITE: begin
          memWrite = 1'b1;
          IorD     = 1'b1;
          retire   = memReady;
          state_d  = memReady ? S_FETCH : S_MEMWRITE;
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = S_RWB;
        end
        S_RWB: begin
          regWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA  = 1'b1;
          ALUOp    = 2'b01;
          pcSource = 1'b1;
          pcEn     = zero;
          retire   = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state      = state_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: instruction table plus hand sequences,
// per-cycle expected outputs pushed to a queue and popped at the falling edge.
module tb_multicycle_main_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        memReady;
  logic        pcEn, pcSource, IorD, memRead, memWrite, irWrite, memToReg, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, ALUOp;
  logic        illegalOp;
  logic [3:0]  state;
  logic [31:0] instrCount;

  logic        pcEn4, pcSource4, IorD4, memRead4, memWrite4, irWrite4, memToReg4, regWrite4, aluSrcA4;
  logic [1:0]  aluSrcB4, ALUOp4;
  logic        illegalOp4;
  logic [3:0]  state4;
  logic [3:0]  instrCount4;

  multicycle_main_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcEn(pcEn), .pcSource(pcSource), .IorD(IorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .ALUOp(ALUOp), .illegalOp(illegalOp), .state(state),
    .instrCount(instrCount)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcEn(pcEn4), .pcSource(pcSource4), .IorD(IorD4), .memRead(memRead4), .memWrite(memWrite4),
    .irWrite(irWrite4), .memToReg(memToReg4), .regWrite(regWrite4), .aluSrcA(aluSrcA4),
    .aluSrcB(aluSrcB4), .ALUOp(ALUOp4), .illegalOp(illegalOp4), .state(state4),
    .instrCount(instrCount4)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [50:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // {pcEn,pcSource,IorD,memRead,memWrite,irWrite,memToReg,regWrite,aluSrcA,aluSrcB,ALUOp,illegalOp,state}
  function automatic logic [18:0] spec_outs(input logic [3:0] st, input logic mr,
                                            input logic z, input logic [6:0] op);
    logic pe, ps, iod, mrd, mwr, irw, m2r, rw, asa, ill;
    logic [1:0] asb, aop;
    {pe, ps, iod, mrd, mwr, irw, m2r, rw, asa, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      4'd0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pe = mr; end
      4'd1: begin
        asb = 2'b10;
        ill = !(op == OP_R || op == OP_LD || op == OP_SD || op == OP_BEQ);
      end
      4'd2: begin asa = 1'b1; asb = 2'b10; end
      4'd3: begin mrd = 1'b1; iod = 1'b1; end
      4'd4: begin rw = 1'b1; m2r = 1'b1; end
      4'd5: begin mwr = 1'b1; iod = 1'b1; end
      4'd6: begin asa = 1'b1; aop = 2'b10; end
      4'd7: begin rw = 1'b1; end
      4'd8: begin asa = 1'b1; aop = 2'b01; ps = 1'b1; pe = z; end
      default: ;
    endcase
    return {pe, ps, iod, mrd, mwr, irw, m2r, rw, asa, asb, aop, ill, st};
  endfunction

  function automatic logic [50:0] actual_word();
    return {pcEn, pcSource, IorD, memRead, memWrite, irWrite, memToReg, regWrite, aluSrcA,
            aluSrcB, ALUOp, illegalOp, state, instrCount};
  endfunction

  // Scoreboard pop/compare, called at the falling edge
  task automatic check_cycle(input string name);
    logic [50:0] exp_w;
    logic [50:0] act_w;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual=%h required=entry", name, actual_word());
      return;
    end
    exp_w = exp_q.pop_front();
    act_w = actual_word();
    if (act_w !== exp_w) begin
      errors++;
      $display("FAIL %s: outs/state actual=%h required=%h count actual=%0d required=%0d",
               name, act_w[50:32], exp_w[50:32], act_w[31:0], exp_w[31:0]);
    end
    checks++;
    if (instrCount4 !== exp_cnt[3:0]) begin
      errors++;
      $display("FAIL %s: cnt4 actual=%0d required=%0d", name, instrCount4, exp_cnt[3:0]);
    end
  endtask

  // Driver: one clock cycle with the expected state for that cycle
  task automatic cyc(input logic [3:0] st, input logic mr, input logic z,
                     input logic [6:0] op, input logic retire, input string name);
    opcode   = op;
    memReady = mr;
    zero     = z;
    exp_q.push_back({spec_outs(st, mr, z, op), exp_cnt});
    @(negedge clk);
    check_cycle(name);
    if (retire) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] junk_op(input logic [6:0] op);
    return (op == OP_R) ? OP_BEQ : OP_R;
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic z, input int fstall, input int mstall);
    logic [6:0] j;
    j = junk_op(op);
    for (int i = 0; i < fstall; i++) cyc(4'd0, 1'b0, 1'($urandom_range(0, 1)), j, 1'b0, "fetch_wait");
    cyc(4'd0, 1'b1, 1'($urandom_range(0, 1)), j, 1'b0, "fetch");
    cyc(4'd1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, 1'b0, "decode");
    case (op)
      OP_R: begin
        cyc(4'd6, 1'($urandom_range(0, 1)), 1'b0, j, 1'b0, "exec");
        cyc(4'd7, 1'($urandom_range(0, 1)), 1'b0, j, 1'b1, "rwb");
      end
      OP_LD: begin
        cyc(4'd2, 1'($urandom_range(0, 1)), 1'b0, OP_SD, 1'b0, "ld_memadr");
        for (int i = 0; i < mstall; i++) cyc(4'd3, 1'b0, 1'b0, j, 1'b0, "memread_wait");
        cyc(4'd3, 1'b1, 1'b0, j, 1'b0, "memread");
        cyc(4'd4, 1'($urandom_range(0, 1)), 1'b0, j, 1'b1, "memwb");
      end
      OP_SD: begin
        cyc(4'd2, 1'($urandom_range(0, 1)), 1'b0, OP_LD, 1'b0, "sd_memadr");
        for (int i = 0; i < mstall; i++) cyc(4'd5, 1'b0, 1'b0, j, 1'b0, "memwrite_wait");
        cyc(4'd5, 1'b1, 1'b0, j, 1'b1, "memwrite");
      end
      OP_BEQ: cyc(4'd8, z, z, j, 1'b1, "branch");
      default: ;
    endcase
  endtask

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         fstall;
    int         mstall;
  } vec_t;

  vec_t tbl[9];

  task automatic check_reset_zero(input string name);
    checks++;
    if (actual_word() !== 51'd0) begin
      errors++;
      $display("FAIL %s: actual=%h required=0", name, actual_word());
    end
    checks++;
    if (instrCount4 !== 4'd0 || state4 !== 4'd0 || memWrite4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_cnt4: cnt actual=%0d state actual=%0d required=0", name, instrCount4, state4);
    end
  endtask

  initial begin
    tbl[0] = '{OP_R,   1'b0, 0, 0};
    tbl[1] = '{OP_LD,  1'b0, 0, 3};
    tbl[2] = '{OP_BEQ, 1'b1, 0, 0};
    tbl[3] = '{OP_BEQ, 1'b0, 0, 0};
    tbl[4] = '{OP_SD,  1'b0, 1, 2};
    tbl[5] = '{OP_ILL, 1'b0, 0, 0};
    tbl[6] = '{OP_LD,  1'b0, 2, 0};
    tbl[7] = '{OP_SD,  1'b0, 0, 0};
    tbl[8] = '{OP_R,   1'b1, 1, 0};

    // Reset held with FETCH-enabling inputs: everything must read zero
    reset    = 1'b1;
    opcode   = OP_R;
    zero     = 1'b1;
    memReady = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_zero("reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_instr(tbl[i].op, tbl[i].z, tbl[i].fstall, tbl[i].mstall);

    // 16 back-to-back R instructions drive the 4-bit counter through 15 -> 0
    for (int i = 0; i < 16; i++) run_instr(OP_R, 1'b0, $urandom_range(0, 1), 0);

    // Reset arriving mid-store: strobes and count clear without waiting for a clock
    cyc(4'd0, 1'b1, 1'b0, OP_R, 1'b0, "abort_fetch");
    cyc(4'd1, 1'b0, 1'b0, OP_SD, 1'b0, "abort_decode");
    cyc(4'd2, 1'b0, 1'b0, OP_LD, 1'b0, "abort_memadr");
    cyc(4'd5, 1'b0, 1'b0, OP_R, 1'b0, "abort_memwrite");
    reset = 1'b1;
    #1;
    check_reset_zero("reset_mid_memwrite");
    exp_cnt = 32'd0;
    @(negedge clk);
    check_reset_zero("reset_mid_memwrite_held");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_SD, 1'b0, 0, 1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
